roi_stream_buffer: RTL

- Parametrised successor to the single ROI memory and fixed 784-cycle readout counter that feed the CNN core.
- Ping-pong buffers one ROI frame of ROI_W×ROI_H pixels written by the downsampler, then streams the completed frame to the CNN with a valid/ready handshake and an end-of-frame marker.
- Adds per-frame pixel preprocessing (pass, invert, threshold, inverted threshold), frame tagging, and overflow accounting.
- Sits between downsample_28x28 and cnn_core_top in the pclk_vid domain.

---
 rtl/roi_stream_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/roi_stream_buffer.sv
// -----------------------------------------------------------------------------
// roi_stream_buffer
//
// Ping-pong ROI frame buffer between the downsampler and the CNN core.
// One bank collects the frame being written while the other bank streams the
// last completed frame out over a valid/ready interface, with per-frame pixel
// preprocessing, a frame id and a saturating dropped-frame counter.
//
// Ports:
//   pclk, rst_n     : clock (rising edge) and async active-low reset
//   wr_en/addr/data : pixel write into the current write bank (row-major)
//   wr_frame_done   : 1-cycle pulse, the write frame is complete
//   mode, thresh    : preprocessing select/level, latched at each handover
//   out_data/valid/ready/last : output pixel stream, out_last on pixel N-1
//   out_frame_id    : id of the frame currently streaming (first frame = 1)
//   busy            : read side is in STREAM
//   drop_cnt        : frames dropped because the read side was busy
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, out_data/out_last/out_frame_id
// hold. out_valid never drops without a transfer until the frame ends.
// -----------------------------------------------------------------------------
module roi_stream_buffer #(
  parameter int ROI_W  = 28,
  parameter int ROI_H  = 28,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10,
  parameter int ID_W   = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_frame_done,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  thresh,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ID_W-1:0]   out_frame_id,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int N     = ROI_W * ROI_H;
  localparam int CNT_W = ADDR_W + 1;   // holds 0..N inclusive
  localparam int MEM_W = ADDR_W + 1;   // index into both banks (2*N entries)

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]   fetch_idx_q, fetch_idx_d;
  logic               s1_valid_q, s1_valid_d;   // ram_q holds a fetched pixel
  logic               s1_last_q, s1_last_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [PIX_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]    frame_id_q, frame_id_d;
  logic [1:0]         mode_q, mode_d;
  logic [PIX_W-1:0]   thresh_q, thresh_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  // ---------------------------------------------------------------------------
  // Bank storage: bank b occupies entries [b*N, b*N+N-1]
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] mem [0:2*N-1];
  logic [PIX_W-1:0] ram_q;
  logic             wr_in_range;
  logic [MEM_W-1:0] wr_index;
  logic [MEM_W-1:0] rd_index;
  logic             rd_en;
  logic             adv;

  assign wr_in_range = ({1'b0, wr_addr} < CNT_W'(N));
  assign wr_index    = wr_bank_q ? (MEM_W'(N) + MEM_W'(wr_addr)) : MEM_W'(wr_addr);
  assign rd_index    = rd_bank_q ? (MEM_W'(N) + MEM_W'(fetch_idx_q)) : MEM_W'(fetch_idx_q);

  // The write uses wr_bank_q, so a write coinciding with wr_frame_done lands in
  // the bank being handed over.
  always_ff @(posedge pclk) begin
    if (wr_en && wr_in_range) mem[wr_index] <= wr_data;
    if (rd_en)                ram_q         <= mem[rd_index];
  end

  function automatic logic [PIX_W-1:0] preprocess(input logic [1:0]       m,
                                                  input logic [PIX_W-1:0] p,
                                                  input logic [PIX_W-1:0] t);
    logic [PIX_W-1:0] r;
    r = p;
    case (m)
      2'd0: r = p;
      2'd1: r = ~p;
      2'd2: r = (p >= t) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      2'd3: r = (p >= t) ? {PIX_W{1'b0}} : {PIX_W{1'b1}};
      default: r = p;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Two-stage read pipeline: RAM output (stage 1) -> output register.
  // The output register advances when empty or accepted; stage 1 refills
  // whenever it advances or is empty. When both are full and stalled, the RAM
  // read is gated so ram_q itself acts as the skid storage.
  // ---------------------------------------------------------------------------
  assign adv   = !out_valid_q || out_ready;
  assign rd_en = (state_q == STREAM) && (fetch_idx_q < CNT_W'(N)) && (adv || !s1_valid_q);

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    fetch_idx_d = fetch_idx_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    frame_id_d  = frame_id_q;
    mode_d      = mode_q;
    thresh_d    = thresh_q;
    drop_cnt_d  = drop_cnt_q;

    if (rd_en) begin
      fetch_idx_d = fetch_idx_q + CNT_W'(1);
      s1_valid_d  = 1'b1;
      s1_last_d   = (fetch_idx_q == CNT_W'(N - 1));
    end else if (adv) begin
      s1_valid_d  = 1'b0;
    end

    if (adv) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) out_data_d = preprocess(mode_q, ram_q, thresh_q);
    end

    // Final beat accepted: return to IDLE; pipeline is already drained.
    if ((state_q == STREAM) && out_valid_q && out_ready && out_last_q) begin
      state_d = IDLE;
    end

    if (wr_frame_done) begin
      if (state_q == IDLE) begin
        state_d     = STREAM;
        rd_bank_d   = wr_bank_q;
        wr_bank_d   = ~wr_bank_q;
        mode_d      = mode;
        thresh_d    = thresh;
        frame_id_d  = frame_id_q + ID_W'(1);
        fetch_idx_d = '0;
        s1_valid_d  = 1'b0;
      end else begin
        // Read side busy (even on its final beat): drop the frame and keep
        // the write bank so the next frame overwrites it.
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      fetch_idx_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      frame_id_q  <= '0;
      mode_q      <= 2'd0;
      thresh_q    <= '0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      fetch_idx_q <= fetch_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      frame_id_q  <= frame_id_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_frame_id = frame_id_q;
  assign busy         = (state_q == STREAM);
  assign drop_cnt     = drop_cnt_q;

endmodule
